// File: rtl/mipsfpga_ahb_gpio_irq_pkg.sv
// mipsfpga_ahb_gpio_irq_pkg
//   Shared definitions for the AHB-Lite GPIO/interrupt slave.
//   - gpio_reg_e      : register index (HADDR[4:2]) of the eight word registers
//   - GPIO_FILT_DEPTH : number of agreeing samples (two stored + current)
//                       needed before a filtered input may change
package mipsfpga_ahb_gpio_irq_pkg;

  typedef enum logic [2:0] {
    H_GPIO_DATA_IN  = 3'd0,
    H_GPIO_DATA_OUT = 3'd1,
    H_GPIO_OUT_SET  = 3'd2,
    H_GPIO_OUT_CLR  = 3'd3,
    H_GPIO_OUT_TGL  = 3'd4,
    H_GPIO_IRQ_EN   = 3'd5,
    H_GPIO_IRQ_BOTH = 3'd6,
    H_GPIO_IRQ_STAT = 3'd7
  } gpio_reg_e;

  localparam int GPIO_FILT_DEPTH = 3;

endpackage

// File: rtl/mipsfpga_ahb_gpio_filter.sv
// mipsfpga_ahb_gpio_filter
//   Per-bit input conditioning: SYNC_STAGES-flop synchroniser, a debounce
//   prescaler producing a sample tick every DB_DIV cycles, and a sample
//   filter that only lets the filtered value follow the pin once the two
//   stored tick samples and the current synchroniser output all agree.
// Ports:
//   clk_i   : clock (rising edge)
//   rst_ni  : asynchronous active-low reset
//   pin_i   : asynchronous pins [W]
//   filt_o  : filtered (debounced) inputs [W]
//   rise_o  : one-cycle strobe, filt_o goes 0->1 on this edge [W]
//   fall_o  : one-cycle strobe, filt_o goes 1->0 on this edge [W]
module mipsfpga_ahb_gpio_filter
  import mipsfpga_ahb_gpio_irq_pkg::*;
#(
  parameter int W           = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_DIV      = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] pin_i,
  output logic [W-1:0] filt_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  localparam int SH = GPIO_FILT_DEPTH - 1;
  localparam int CW = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_DIV - 1);

  logic [SYNC_STAGES-1:0][W-1:0] sync_q;
  logic [SH-1:0][W-1:0]          shift_q;
  logic [W-1:0]                  filt_q, filt_d, sync_out, agree, upd;
  logic [CW-1:0]                 pre_q, pre_d;
  logic                          tick;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign tick     = (pre_q == LAST);
  assign pre_d    = tick ? '0 : pre_q + CW'(1);

  // A bit may only move when every stored sample matches the live
  // synchroniser output, and that common value differs from filt.
  always_comb begin
    agree = '1;
    for (int i = 0; i < SH; i++) begin
      agree = agree & ~(shift_q[i] ^ sync_out);
    end
    upd    = tick ? (agree & (sync_out ^ filt_q)) : '0;
    filt_d = filt_q ^ upd;
  end

  assign filt_o = filt_q;
  assign rise_o = upd & sync_out;
  assign fall_o = upd & ~sync_out;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      shift_q <= '0;
      filt_q  <= '0;
      pre_q   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      pre_q  <= pre_d;
      filt_q <= filt_d;
      // shift_q[0] is the newest tick sample
      if (tick) shift_q <= {shift_q[SH-2:0], sync_out};
    end
  end

endmodule

// File: rtl/mipsfpga_ahb_gpio_irq.sv
// mipsfpga_ahb_gpio_irq
//   AHB-Lite GPIO slave: debounced inputs, set/clear/toggle outputs,
//   per-pin edge capture into a W1C status register and one level irq.
//   Writes commit on the HCLK edge where HSEL & HWRITE (single-cycle,
//   always ready); reads are combinational from HADDR[4:2].
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   HADDR[4:0]    : byte address, HADDR[1:0] ignored
//   HWDATA[31:0]  : write data (low N bits used)
//   HWRITE, HSEL  : write strobe, slave select
//   HRDATA[31:0]  : zero-extended read data
//   gpio_in       : asynchronous input pins [N_IN]
//   gpio_out      : registered output pins [N_OUT]
//   irq           : registered level interrupt
module mipsfpga_ahb_gpio_irq
  import mipsfpga_ahb_gpio_irq_pkg::*;
#(
  parameter int               N_IN        = 16,
  parameter int               N_OUT       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter int               DB_DIV      = 1,
  parameter logic [N_OUT-1:0] OUT_RESET   = '0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [4:0]       HADDR,
  input  logic [31:0]      HWDATA,
  input  logic             HWRITE,
  input  logic             HSEL,
  output logic [31:0]      HRDATA,
  input  logic [N_IN-1:0]  gpio_in,
  output logic [N_OUT-1:0] gpio_out,
  output logic             irq
);

  logic [N_IN-1:0]  filt, rise, fall, evt, wd_in, stat_clr;
  logic [N_IN-1:0]  en_q, en_d, both_q, both_d, stat_q, stat_d;
  logic [N_OUT-1:0] dout_q, dout_d, wd_out;
  logic             irq_q, irq_d, wr;
  gpio_reg_e        reg_sel;
  logic             unused_bits;

  mipsfpga_ahb_gpio_filter #(
    .W          (N_IN),
    .SYNC_STAGES(SYNC_STAGES),
    .DB_DIV     (DB_DIV)
  ) u_filter (
    .clk_i (HCLK),
    .rst_ni(HRESETn),
    .pin_i (gpio_in),
    .filt_o(filt),
    .rise_o(rise),
    .fall_o(fall)
  );

  assign reg_sel     = gpio_reg_e'(HADDR[4:2]);
  assign wr          = HSEL & HWRITE;
  assign wd_in       = HWDATA[N_IN-1:0];
  assign wd_out      = HWDATA[N_OUT-1:0];
  assign unused_bits = ^{HADDR[1:0], HWDATA};

  // Falling edges only count where IRQ_BOTH is set.
  assign evt = rise | (fall & both_q);

  always_comb begin
    dout_d   = dout_q;
    en_d     = en_q;
    both_d   = both_q;
    stat_clr = '0;
    if (wr) begin
      unique case (reg_sel)
        H_GPIO_DATA_OUT: dout_d   = wd_out;
        H_GPIO_OUT_SET:  dout_d   = dout_q | wd_out;
        H_GPIO_OUT_CLR:  dout_d   = dout_q & ~wd_out;
        H_GPIO_OUT_TGL:  dout_d   = dout_q ^ wd_out;
        H_GPIO_IRQ_EN:   en_d     = wd_in;
        H_GPIO_IRQ_BOTH: both_d   = wd_in;
        H_GPIO_IRQ_STAT: stat_clr = wd_in;
        default: ;
      endcase
    end
    // A new event wins over a same-cycle W1C of the same bit.
    stat_d = (stat_q & ~stat_clr) | evt;
    irq_d  = |(stat_q & en_q);
  end

  always_comb begin
    HRDATA = '0;
    unique case (reg_sel)
      H_GPIO_DATA_IN:  HRDATA[N_IN-1:0]  = filt;
      H_GPIO_DATA_OUT: HRDATA[N_OUT-1:0] = dout_q;
      H_GPIO_IRQ_EN:   HRDATA[N_IN-1:0]  = en_q;
      H_GPIO_IRQ_BOTH: HRDATA[N_IN-1:0]  = both_q;
      H_GPIO_IRQ_STAT: HRDATA[N_IN-1:0]  = stat_q;
      default:         HRDATA            = '0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dout_q <= OUT_RESET;
      en_q   <= '0;
      both_q <= '0;
      stat_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      en_q   <= en_d;
      both_q <= both_d;
      stat_q <= stat_d;
      irq_q  <= irq_d;
    end
  end

  assign gpio_out = dout_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_mipsfpga_ahb_gpio_irq.sv
// tb_mipsfpga_ahb_gpio_irq
//   Two instances share clock, reset, bus and pins: dut_a with DB_DIV=1 and
//   dut_b with DB_DIV=4, both with OUT_RESET=0x00AA. A behavioural model
//   predicts filtered inputs, status, outputs and irq for each instance.
module tb_mipsfpga_ahb_gpio_irq;

  localparam int DIV_A = 1;
  localparam int DIV_B = 4;
  localparam int SS    = 2;

  logic        HCLK, HRESETn, HWRITE, HSEL;
  logic [4:0]  HADDR;
  logic [31:0] HWDATA, hr_a, hr_b;
  logic [15:0] gpio_in, gpio_out_a, gpio_out_b;
  logic        irq_a, irq_b;

  int n_checks = 0;
  int n_fail   = 0;

  mipsfpga_ahb_gpio_irq #(.N_IN(16), .N_OUT(16), .SYNC_STAGES(SS), .DB_DIV(DIV_A),
                          .OUT_RESET(16'h00AA)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HSEL(HSEL), .HRDATA(hr_a), .gpio_in(gpio_in), .gpio_out(gpio_out_a), .irq(irq_a));

  mipsfpga_ahb_gpio_irq #(.N_IN(16), .N_OUT(16), .SYNC_STAGES(SS), .DB_DIV(DIV_B),
                          .OUT_RESET(16'h00AA)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HSEL(HSEL), .HRDATA(hr_b), .gpio_in(gpio_in), .gpio_out(gpio_out_b), .irq(irq_b));

  // clock / reset
  initial HCLK = 1'b0;
  always #10 HCLK = ~HCLK;

  // ---------------- reference model ----------------
  logic [15:0] pq[$];                 // pin history; front = synchroniser output
  logic [15:0] m_filt[2], m_s0[2], m_s1[2], m_stat[2];
  logic        m_irq[2];
  int          m_cnt[2];
  logic [15:0] m_dout, m_en, m_both;

  task automatic model_reset();
    pq.delete();
    for (int i = 0; i < SS; i++) pq.push_back(16'h0);
    for (int d = 0; d < 2; d++) begin
      m_filt[d] = '0; m_s0[d] = '0; m_s1[d] = '0; m_stat[d] = '0;
      m_irq[d] = 1'b0; m_cnt[d] = 0;
    end
    m_dout = 16'h00AA; m_en = '0; m_both = '0;
  endtask

  // Predicts the effect of the coming rising edge from the current inputs.
  task automatic model_step();
    logic [15:0] so, evt, clr, wd;
    logic        wr, tick, irq_n;
    logic [2:0]  a;
    so = pq.pop_front();
    pq.push_back(gpio_in);
    wr  = HSEL && HWRITE;
    a   = HADDR[4:2];
    wd  = HWDATA[15:0];
    clr = (wr && a == 3'd7) ? wd : 16'h0;
    for (int d = 0; d < 2; d++) begin
      irq_n = |(m_stat[d] & m_en);
      evt   = '0;
      tick  = (m_cnt[d] == ((d == 0) ? DIV_A : DIV_B) - 1);
      m_cnt[d] = tick ? 0 : m_cnt[d] + 1;
      if (tick) begin
        // three successive tick samples agree and differ from filt
        for (int b = 0; b < 16; b++) begin
          if (so[b] == m_s0[d][b] && so[b] == m_s1[d][b] && so[b] != m_filt[d][b]) begin
            m_filt[d][b] = so[b];
            if (so[b] || m_both[b]) evt[b] = 1'b1;
          end
        end
        m_s1[d] = m_s0[d];
        m_s0[d] = so;
      end
      m_stat[d] = (m_stat[d] & ~clr) | evt;
      m_irq[d]  = irq_n;
    end
    if (wr) begin
      case (a)
        3'd1: m_dout = wd;
        3'd2: m_dout = m_dout | wd;
        3'd3: m_dout = m_dout & ~wd;
        3'd4: m_dout = m_dout ^ wd;
        3'd5: m_en   = wd;
        3'd6: m_both = wd;
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] mread(int d, logic [2:0] a);
    case (a)
      3'd0:    return {16'h0, m_filt[d]};
      3'd1:    return {16'h0, m_dout};
      3'd5:    return {16'h0, m_en};
      3'd6:    return {16'h0, m_both};
      3'd7:    return {16'h0, m_stat[d]};
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic cyc();
    model_step();
    @(posedge HCLK);
    @(negedge HCLK);
    chk("gpio_out_a", {16'h0, gpio_out_a}, {16'h0, m_dout});
    chk("gpio_out_b", {16'h0, gpio_out_b}, {16'h0, m_dout});
    chk("irq_a", {31'h0, irq_a}, {31'h0, m_irq[0]});
    chk("irq_b", {31'h0, irq_b}, {31'h0, m_irq[1]});
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    HSEL = 1'b1; HWRITE = 1'b1; HADDR = a; HWDATA = v;
    cyc();
    HSEL = 1'b0; HWRITE = 1'b0; HWDATA = '0;
  endtask

  task automatic rd_chk(input string tag, input int d, input logic [4:0] a, input logic [31:0] exp);
    HSEL = 1'b1; HWRITE = 1'b0; HADDR = a;
    #1;
    chk(tag, (d == 0) ? hr_a : hr_b, exp);
  endtask

  task automatic rd_m(input string tag, input int d, input logic [4:0] a);
    rd_chk(tag, d, a, mread(d, a[4:2]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] ra;
    HRESETn = 1'b0; HSEL = 1'b0; HWRITE = 1'b0; HADDR = '0; HWDATA = '0; gpio_in = '0;
    model_reset();
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;

    // reset state
    chk("rst_gpio_out", {16'h0, gpio_out_a}, 32'h00AA);
    chk("rst_irq", {31'h0, irq_a}, 32'h0);
    for (int i = 0; i < 8; i++) rd_chk("rst_read", 0, 5'(i * 4), (i == 1) ? 32'h00AA : 32'h0);

    // output operations
    wr(5'h04, 32'h0000_00F0);
    chk("dout_write", {16'h0, gpio_out_a}, 32'h00F0);
    wr(5'h08, 32'h0000_0003);
    chk("out_set", {16'h0, gpio_out_a}, 32'h00F3);
    wr(5'h0C, 32'h0000_0010);
    chk("out_clr", {16'h0, gpio_out_a}, 32'h00E3);
    wr(5'h10, 32'h0000_8001);
    chk("out_tgl", {16'h0, gpio_out_a}, 32'h80E2);
    rd_chk("wo_read_0", 0, 5'h08, 32'h0);
    rd_chk("dout_read", 0, 5'h04, 32'h80E2);

    // debounce: 2-cycle pulse rejected
    gpio_in = 16'h0001;
    repeat (2) cyc();
    gpio_in = 16'h0000;
    repeat (6) cyc();
    rd_chk("glitch2_din", 0, 5'h00, 32'h0);
    rd_chk("glitch2_stat", 0, 5'h1C, 32'h0);
    rd_m("glitch2_stat_b", 1, 5'h1C);

    // debounce: 3-cycle pulse accepted at edge k+4
    gpio_in = 16'h0001;
    repeat (3) cyc();
    gpio_in = 16'h0000;
    cyc();
    rd_chk("pulse3_din_k3", 0, 5'h00, 32'h0);
    cyc();
    rd_chk("pulse3_din_k4", 0, 5'h00, 32'h1);
    rd_chk("pulse3_stat", 0, 5'h1C, 32'h1);
    rd_m("pulse3_din_b", 1, 5'h00);
    repeat (8) cyc();
    wr(5'h1C, 32'hFFFF);

    // edge modes
    wr(5'h14, 32'h3);
    wr(5'h18, 32'h2);
    gpio_in = 16'h0003;
    repeat (5) cyc();
    rd_chk("rise_stat", 0, 5'h1C, 32'h3);
    chk("rise_irq_before", {31'h0, irq_a}, 32'h0);
    cyc();
    chk("rise_irq_after", {31'h0, irq_a}, 32'h1);
    wr(5'h1C, 32'h3);
    gpio_in = 16'h0000;
    repeat (5) cyc();
    rd_chk("fall_stat", 0, 5'h1C, 32'h2);
    chk("fall_irq_before", {31'h0, irq_a}, 32'h0);
    cyc();
    chk("fall_irq_after", {31'h0, irq_a}, 32'h1);

    // collision: W1C of bit 4 on the edge of its rising event
    wr(5'h1C, 32'hFFFF);
    wr(5'h14, 32'h10);
    gpio_in = 16'h0010;
    repeat (4) cyc();
    wr(5'h1C, 32'h10);
    rd_chk("collide_stat", 0, 5'h1C, 32'h10);
    cyc();
    chk("collide_irq", {31'h0, irq_a}, 32'h1);
    cyc();
    chk("collide_irq_hold", {31'h0, irq_a}, 32'h1);
    gpio_in = 16'h0000;
    repeat (8) cyc();

    // divider: pulse lengths swept against prescaler phase on dut_b
    for (int li = 0; li < 3; li++) begin
      for (int p = 0; p < 4; p++) begin
        wr(5'h1C, 32'hFFFF);
        repeat (p) cyc();
        gpio_in = 16'h0100;
        repeat (8 + 2 * li) cyc();
        gpio_in = 16'h0000;
        repeat (24) cyc();
        rd_m("div_stat_b", 1, 5'h1C);
        rd_m("div_stat_a", 0, 5'h1C);
        if (li != 1) rd_chk("div_stat_b_const", 1, 5'h1C, (li == 2) ? 32'h100 : 32'h0);
      end
    end

    // randomized pins and register traffic
    for (int it = 0; it < 150; it++) begin
      gpio_in = 16'($urandom);
      if ($urandom_range(0, 2) == 0) wr(5'($urandom_range(0, 31)), $urandom);
      repeat ($urandom_range(1, 5)) cyc();
      ra = 5'($urandom_range(0, 31));
      rd_m("rand_rd_a", 0, ra);
      rd_m("rand_rd_b", 1, ra);
    end

    // reset mid-activity
    wr(5'h18, 32'h0);
    wr(5'h14, 32'hFF);
    gpio_in = 16'h0000;
    repeat (16) cyc();
    wr(5'h1C, 32'hFFFF);
    gpio_in = 16'h00FF;
    repeat (16) cyc();
    rd_chk("pre_rst_stat", 0, 5'h1C, 32'hFF);
    wr(5'h04, 32'h1234);
    chk("pre_rst_dout", {16'h0, gpio_out_a}, 32'h1234);
    chk("pre_rst_irq", {31'h0, irq_a}, 32'h1);
    HRESETn = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_gpio_out", {16'h0, gpio_out_a}, 32'h00AA);
    chk("mid_rst_irq", {31'h0, irq_a}, 32'h0);
    for (int i = 0; i < 8; i++) rd_chk("mid_rst_read", 0, 5'(i * 4), (i == 1) ? 32'h00AA : 32'h0);
    @(negedge HCLK);
    model_reset();
    HRESETn = 1'b1;
    // pins held high through reset produce rising events after latency
    repeat (5) cyc();
    rd_chk("post_rst_stat", 0, 5'h1C, 32'hFF);
    repeat (16) cyc();
    rd_m("post_rst_stat_b", 1, 5'h1C);
    rd_m("post_rst_din_b", 1, 5'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
